alu_exec_unit: RTL and testbench

//  Multi-cycle integer ALU for the MIPS datapath. It consumes the 4-bit aluCtrl code

---
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Issue/writeback handshake bundle for the multi-cycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluCtrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, aluCtrl, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, aluCtrl, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Multi-cycle integer ALU; single-cycle logic/arith, serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0]     c_OP_ADD   = 4'b0000;
    localparam logic [3:0]     c_OP_SUB   = 4'b0001;
    localparam logic [3:0]     c_OP_AND   = 4'b0010;
    localparam logic [3:0]     c_OP_OR    = 4'b0011;
    localparam logic [3:0]     c_OP_SLL   = 4'b0100;
    localparam logic [3:0]     c_OP_SRL   = 4'b0101;
    localparam logic [3:0]     c_OP_SLT   = 4'b0110;
    localparam logic [SHW-1:0] c_CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_stage;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_shift;
    logic             w_go_shift;
    logic             w_undef;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_shifted;

    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_shift = (bus.aluCtrl == c_OP_SLL) || (bus.aluCtrl == c_OP_SRL);
    // A zero-distance shift takes the single-cycle path and returns b unchanged
    assign w_go_shift = w_is_shift && (bus.shamt != '0);
    assign w_shifted  = r_left ? {r_stage[WIDTH-2:0], 1'b0} : {1'b0, r_stage[WIDTH-1:1]};

    always_comb begin
        w_alu   = '0;
        w_undef = 1'b0;
        case (bus.aluCtrl)
            c_OP_ADD: w_alu = bus.a + bus.b;
            c_OP_SUB: w_alu = bus.a - bus.b;
            c_OP_AND: w_alu = bus.a & bus.b;
            c_OP_OR:  w_alu = bus.a | bus.b;
            c_OP_SLL: w_alu = bus.b;
            c_OP_SRL: w_alu = bus.b;
            c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default:  w_undef = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_go_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage  <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_go_shift) begin
                            r_stage <= bus.b;
                            r_cnt   <= bus.shamt;
                            r_left  <= (bus.aluCtrl == c_OP_SLL);
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_err    <= w_undef;
                        end
                    end
                end
                S_SHIFT: begin
                    r_stage <= w_shifted;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_shifted;
                        r_zero   <= (w_shifted == '0);
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE) && !rst;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    alu_exec_unit_if #(.WIDTH(32), .SHW(5)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: inputs change at posedge+1, so a negedge sample matches what the DUT sees next edge
    bit seen = 0;
    int fs   = 0;
    always @(negedge clk) begin : mon
        exp_t x;
        if (rst) begin
            seen = 0;
        end else begin
            if (bus.out_valid && !seen) begin
                seen = 1;
                fs   = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    x = sbq.pop_front();
                    chk("result",  bus.result, x.res);
                    chk("zero",    {31'd0, bus.zero}, {31'd0, x.z});
                    chk("err",     {31'd0, bus.err},  {31'd0, x.e});
                    chk("latency", fs - x.acc + 1, x.lat);
                end
                seen = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er, input logic ez,
                         input logic ee, input int lat, input bit push);
        exp_t x;
        int   n;
        bus.aluCtrl  = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (push) begin
                x.res = er; x.z = ez; x.e = ee; x.lat = lat; x.acc = cyc;
                sbq.push_back(x);
            end
            bus.in_valid = 1'b0;
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.shamt    = 5'($urandom);
            bus.aluCtrl  = 4'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0 || bus.out_valid) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit quiet;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.aluCtrl   = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;

        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_result",    bus.result,             32'd0);
            chk("rst_err",       {31'd0, bus.err},       32'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        issue(4'b0000, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0001, 32'd5,        32'd5,        5'd0,  32'h0,        1'b1, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0110, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0110, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0010, 32'hF0F0,     32'h0FF0,     5'd0,  32'h00F0,     1'b0, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0011, 32'hF0F0,     32'h0FF0,     5'd0,  32'hFFF0,     1'b0, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0100, 32'hDEAD,     32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0, 32, 1'b1); wait_drain();
        issue(4'b0101, 32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 5,  1'b1); wait_drain();
        issue(4'b0100, 32'h0,        32'h1234,     5'd0,  32'h1234,     1'b0, 1'b0, 1,  1'b1); wait_drain();
        issue(4'b0101, 32'h0,        32'h0000FF00, 5'd8,  32'h000000FF, 1'b0, 1'b0, 9,  1'b1); wait_drain();
        issue(4'b0101, 32'h0,        32'h00000001, 5'd1,  32'h0,        1'b1, 1'b0, 2,  1'b1); wait_drain();
        issue(4'b1010, 32'h5,        32'h7,        5'd0,  32'h0,        1'b1, 1'b1, 1,  1'b1); wait_drain();

        // Downstream back-pressure while a competing request waits upstream
        bus.out_ready = 1'b0;
        issue(4'b0000, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 1, 1'b1);
        bus.aluCtrl  = 4'b0001;
        bus.a        = 32'd9;
        bus.b        = 32'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_result",    bus.result,             32'd7);
            chk("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_drain();

        // Reset in the middle of a long shift drops the operation
        issue(4'b0100, 32'h0, 32'h1, 5'd20, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) quiet = 1'b0;
        end
        chk("midrst_no_output", {31'd0, quiet}, 32'd1);
        @(posedge clk); #1;

        issue(4'b0000, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1, 1'b1);
        wait_drain();
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
